// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants, state type and digit check for the BCD serial adder/subtractor
package bcd_pkg;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam logic [3:0] BCD_ADJ     = 4'd6;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } bcd_state_t;

  // True when a nibble is not a legal decimal digit
  function automatic logic bcd_digit_bad(input logic [BCD_DIGIT_W-1:0] d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - combinational single-digit BCD add with optional 9's complement of B
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] da,
  input  logic [BCD_DIGIT_W-1:0] db,
  input  logic                   sub,
  input  logic                   cin,
  output logic [BCD_DIGIT_W-1:0] digit,
  output logic                   cout
);

  logic [BCD_DIGIT_W-1:0] db_eff;
  logic [BCD_DIGIT_W:0]   t;

  // Binary sum of the digit pair, then decimal adjust when it exceeds 9
  always_comb begin
    db_eff = sub ? (BCD_MAX - db) : db;
    t      = {1'b0, da} + {1'b0, db_eff} + {{BCD_DIGIT_W{1'b0}}, cin};
    if (t > {1'b0, BCD_MAX}) begin
      digit = t[BCD_DIGIT_W-1:0] + BCD_ADJ;
      cout  = 1'b1;
    end else begin
      digit = t[BCD_DIGIT_W-1:0];
      cout  = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_addsub.sv
// rtl/bcd_serial_addsub.sv - digit-serial packed-BCD adder/subtractor, optional input check via BCD_INPUT_CHECK_EN
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  carry_out,
  output logic                  err
);

  localparam int               CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIGITS - 1);

  bcd_state_t state, state_nxt;

  logic [CNT_W-1:0]                    cnt;
  logic [DIGITS-1:0][BCD_DIGIT_W-1:0]  a_q;
  logic [DIGITS-1:0][BCD_DIGIT_W-1:0]  b_q;
  logic [DIGITS-1:0][BCD_DIGIT_W-1:0]  sum_q;
  logic                                sub_q;
  logic                                carry_q;
  logic                                carry_out_q;
  logic [BCD_DIGIT_W-1:0]              dig;
  logic                                dig_cout;
  logic                                accept;
  logic                                last_digit;

  assign accept     = in_valid && (state == IDLE);
  assign last_digit = (cnt == LAST);

  // One shared digit adder; the counter walks it across the latched operands
  bcd_digit_add u_digit (
    .da    (a_q[cnt]),
    .db    (b_q[cnt]),
    .sub   (sub_q),
    .cin   (carry_q),
    .digit (dig),
    .cout  (dig_cout)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs; no overlap between result and new input
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        if (last_digit) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture and per-digit result accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= a;
            b_q     <= b;
            sub_q   <= sub;
            carry_q <= sub;
            cnt     <= '0;
          end
        end
        CALC: begin
          sum_q[cnt] <= dig;
          carry_q    <= dig_cout;
          cnt        <= cnt + CNT_W'(1);
          if (last_digit) carry_out_q <= dig_cout;
        end
        default: ;
      endcase
    end
  end

  assign sum       = sum_q;
  assign carry_out = carry_out_q;

`ifdef BCD_INPUT_CHECK_EN
  logic bad_in;
  logic err_q;

  // Any non-decimal nibble in either operand at acceptance time
  always_comb begin
    bad_in = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      bad_in = bad_in | bcd_digit_bad(a[4*k +: 4]) | bcd_digit_bad(b[4*k +: 4]);
    end
  end

  // Error flag travels with the operation and is replaced on the next acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_q <= 1'b0;
    else if (accept) err_q <= bad_in;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
